// File: rtl/bar_meter_pkg.sv
// Shared widths, FSM state type and counter sizing for the bar-graph peak meter.
package bar_meter_pkg;

  localparam int LEVEL_W = 3;
  localparam int BAR_W   = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    DECAY = 2'd2
  } meter_state_t;

  // Down-counter width for a reload of n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/level_bar_decode.sv
// Combinational decode of a level into a thermometer bar and a one-hot marker at bit level-1.
module level_bar_decode
  import bar_meter_pkg::*;
(
  input  logic [LEVEL_W-1:0] i_level,
  output logic [BAR_W-1:0]   o_bar,
  output logic [BAR_W-1:0]   o_marker
);

  always_comb begin
    o_bar    = '0;
    o_marker = '0;
    for (int i = 0; i < BAR_W; i++) begin
      o_bar[i]    = (i < int'(i_level));
      o_marker[i] = (int'(i_level) == i + 1);
    end
  end

endmodule

// File: rtl/bar_meter_ctrl.sv
// Peak-hold controller: tracks the current level and a peak marker that holds,
// then decays one step at a time back to the level.
module bar_meter_ctrl
  import bar_meter_pkg::*;
#(
  parameter int HOLD_CYCLES  = 8,
  parameter int DECAY_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic [LEVEL_W-1:0] sample,
  input  logic               sample_valid,
  output logic [LEVEL_W-1:0] level,
  output logic [LEVEL_W-1:0] peak,
  output logic [BAR_W-1:0]   bar,
  output logic [BAR_W-1:0]   peak_bar,
  output logic               holding
);

  localparam int HOLD_W  = cnt_width(HOLD_CYCLES);
  localparam int DECAY_W = cnt_width(DECAY_CYCLES);
  localparam logic [HOLD_W-1:0]  HOLD_RELOAD  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [DECAY_W-1:0] DECAY_RELOAD = DECAY_W'(DECAY_CYCLES - 1);

  meter_state_t       r_state;
  logic [LEVEL_W-1:0] r_level;
  logic [LEVEL_W-1:0] r_peak;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [DECAY_W-1:0] r_decay_cnt;

  meter_state_t       w_state_next;
  logic [LEVEL_W-1:0] w_level_next;
  logic [LEVEL_W-1:0] w_peak_next;
  logic [HOLD_W-1:0]  w_hold_next;
  logic [DECAY_W-1:0] w_decay_next;
  logic               w_trigger;
  logic               w_restart;
  logic               w_peak_reaches_level;
  logic [BAR_W-1:0]   w_level_marker_unused;
  logic [BAR_W-1:0]   w_peak_bar_unused;

  assign w_level_next = sample_valid ? sample : r_level;
  assign w_trigger    = sample_valid && (sample >= r_peak) && (sample != '0);
  // A lower sample only starts a hold from IDLE; in HOLD/DECAY the running timer is left alone.
  assign w_restart    = sample_valid && (sample < r_peak) && (r_state == IDLE);
  assign w_peak_reaches_level =
    ({1'b0, r_peak} <= ({1'b0, w_level_next} + (LEVEL_W + 1)'(1)));

  always_comb begin
    w_state_next = r_state;
    w_peak_next  = r_peak;
    w_hold_next  = r_hold_cnt;
    w_decay_next = r_decay_cnt;
    if (w_trigger) begin
      w_peak_next  = sample;
      w_state_next = HOLD;
      w_hold_next  = HOLD_RELOAD;
    end else if (w_restart) begin
      w_state_next = HOLD;
      w_hold_next  = HOLD_RELOAD;
    end else begin
      case (r_state)
        HOLD: begin
          if (r_hold_cnt == '0) begin
            w_state_next = DECAY;
            w_decay_next = DECAY_RELOAD;
          end else begin
            w_hold_next = r_hold_cnt - HOLD_W'(1);
          end
        end
        DECAY: begin
          if (r_decay_cnt == '0) begin
            if (w_peak_reaches_level) begin
              w_peak_next  = w_level_next;
              w_state_next = IDLE;
            end else begin
              w_peak_next  = r_peak - LEVEL_W'(1);
              w_decay_next = DECAY_RELOAD;
            end
          end else begin
            w_decay_next = r_decay_cnt - DECAY_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_state     <= IDLE;
      r_level     <= '0;
      r_peak      <= '0;
      r_hold_cnt  <= '0;
      r_decay_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_level     <= w_level_next;
      r_peak      <= w_peak_next;
      r_hold_cnt  <= w_hold_next;
      r_decay_cnt <= w_decay_next;
    end
  end

  assign level   = r_level;
  assign peak    = r_peak;
  assign holding = (r_state != IDLE);

  level_bar_decode u_level_decode (
    .i_level  (r_level),
    .o_bar    (bar),
    .o_marker (w_level_marker_unused)
  );

  level_bar_decode u_peak_decode (
    .i_level  (r_peak),
    .o_bar    (w_peak_bar_unused),
    .o_marker (peak_bar)
  );

endmodule

// File: doc/bar_meter_ctrl.md
# bar_meter_ctrl

Peak-hold controller for the 7-segment bar-graph level display. It accepts 3-bit level samples and tracks the current level. It also keeps a peak marker that holds for a programmable time, then decays one step at a time back down to the current level. It drives the thermometer-coded bar and a one-hot peak marker for the LED column, and sits between the sampling front end and the LED drivers.

## Interface
- `HOLD_CYCLES`, default 8: cycles the peak is held after a (re)trigger; legal range ≥1.
- `DECAY_CYCLES`, default 4: cycles between successive one-step peak decrements; legal range ≥1.
- Reset is synchronous and active-high; one clock.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `clear`  in  1  synchronous soft clear, lower priority than `reset`.
- `sample`  in  3  new level, 0..7.
- `sample_valid`  in  1  `sample` is accepted this cycle when high. No backpressure.
- `level`  out  3  registered current level.
- `peak`  out  3  registered peak marker level; always ≥ `level`.
- `bar`  out  7  thermometer code of `level`: bit i set iff i < `level`.
- `peak_bar`  out  7  one-hot at bit `peak`-1; all zero when `peak`==0.
- `holding`  out  1  high while the FSM is in HOLD or DECAY.

## Operation
- States: IDLE (`peak`==`level`), HOLD, DECAY.
- Reset values: `level`=0, `peak`=0, state IDLE, both counters 0, so `bar`, `peak_bar` and `holding` are all 0.
- Priority order is `reset` > `clear` > sample handling > timer activity.
- `clear` has the same effect as reset. A sample presented in the same cycle is dropped.
- Accepted sample: `level` ← `sample`, unconditionally.
- Trigger condition is `sample` ≥ `peak` and `sample` ≠ 0. On a trigger:
  - `peak` ← `sample`.
  - State ← HOLD.
  - hold_cnt ← HOLD_CYCLES-1.
  - This applies from any state and overrides any same-cycle timer event.
- Sample < `peak` while in IDLE: state ← HOLD, hold_cnt reloaded, `peak` unchanged.
- Sample < `peak` while in HOLD or DECAY: no effect on the FSM or the counters.
- Sample of 0 with `peak`==0: remain IDLE.
- HOLD with no trigger:
  - If hold_cnt==0: state ← DECAY, decay_cnt ← DECAY_CYCLES-1.
  - Otherwise decrement hold_cnt.
- DECAY with no trigger:
  - If decay_cnt==0 and `peak`-1 ≤ level_next: `peak` ← level_next, state ← IDLE.
  - If decay_cnt==0 otherwise: `peak` ← `peak`-1 and decay_cnt is reloaded.
  - If decay_cnt≠0: decrement decay_cnt.
- level_next is the value of `level` after this cycle's update. `peak` never goes below it and never wraps below 0.
- Counter widths are $clog2 of the parameter, with a minimum of 1 bit. Counters are unsigned and down-counting only.

## Timing
- Sample accepted at edge N: `level`, `bar`, `peak` and `peak_bar` reflect it after edge N, i.e. in cycle N+1.
- `bar` and `peak_bar` are pure combinational decodes of the registered `level` and `peak`. No extra latency.
- After a trigger accepted in cycle 0, `peak` holds for HOLD_CYCLES+DECAY_CYCLES cycles (cycles 1..12 with defaults). The first decrement is visible in cycle HOLD_CYCLES+DECAY_CYCLES+1.
- Each further step is visible DECAY_CYCLES cycles after the previous one.
- `holding` deasserts in the same cycle that `peak` returns to `level`.
- `reset` or `clear` mid-HOLD/DECAY: all outputs read 0 in the next cycle.

## Structure
- Package `bar_meter_pkg` holds:
  - `LEVEL_W`=3 and `BAR_W`=7.
  - A typedef enum `meter_state_t` {IDLE, HOLD, DECAY}.
- Sub-module `level_bar_decode`: purely combinational. It maps a `LEVEL_W` value to a thermometer bar and a one-hot marker, and is instantiated twice (for `level` and for `peak`).
- The FSM and both counters live in `bar_meter_ctrl`.

## Test plan
- **Reset:** assert `reset` for 2 cycles with `sample_valid`=1, `sample`=5 → `level`=`peak`=0, `bar`=`peak_bar`=0000000, `holding`=0.
- **Hold then decay (defaults):** `sample`=5 at cycle 0, then `sample`=1 at cycle 1.
  - `bar`=0000001 from cycle 2.
  - `peak`=5 (`peak_bar`=0010000) for cycles 1..12.
  - `peak`=4 at cycle 13, 3 at 17, 2 at 21, and 1 with `holding`=0 at 25.
- **Retrigger at decay boundary:** during DECAY with decay_cnt==0, present `sample`=6 → next cycle `peak`=6, state HOLD, no decrement; the hold restarts a full HOLD_CYCLES period.
- **Full scale and decay to zero:** `sample`=7, then 0 → `bar`=1111111 and then 0000000. `peak_bar` goes 1000000 → … → 0000001 → 0000000, and the FSM ends in IDLE.
- **Clear collision:** mid-HOLD, assert `clear` with `sample_valid`=1, `sample`=3 → next cycle all outputs 0, IDLE, sample dropped.
- **Parameter sweep:** HOLD_CYCLES=1, DECAY_CYCLES=1. `sample`=4 at cycle 0, then 0 → `peak` reads 4,4,3,2,1,0 in cycles 1..6.
